// File: rtl/issue_pair.sv
// Dual-issue pairing stage: issues slots A/B together, or splits a dependent pair over two cycles.
// Optional pending-write scoreboard compiled in with ISSUE_SCOREBOARD_EN.
module issue_pair (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_A_rs1,
  input  logic [4:0] in_A_rs2,
  input  logic [4:0] in_A_rd,
  input  logic [4:0] in_B_rs1,
  input  logic [4:0] in_B_rs2,
  input  logic [4:0] in_B_rd,
  input  logic       in_A_wr,
  input  logic       in_B_wr,
  input  logic       in_B_valid,
  input  logic       hold,
  input  logic [4:0] wb_A_rd,
  input  logic [4:0] wb_B_rd,
  input  logic       wb_A_wr,
  input  logic       wb_B_wr,
  output logic       out_A_valid,
  output logic       out_B_valid,
  output logic [4:0] out_A_rs1,
  output logic [4:0] out_A_rs2,
  output logic [4:0] out_A_rd,
  output logic [4:0] out_B_rs1,
  output logic [4:0] out_B_rs2,
  output logic [4:0] out_B_rd,
  output logic       out_A_wr,
  output logic       out_B_wr,
  output logic       dbg_state
);
  // Handshake: a pair is taken on a rising edge where in_valid & in_ready;
  // in_ready never depends on in_valid.
  localparam logic [0:0] ST_PAIR  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  logic [0:0] r_state;
  logic [4:0] r_b_rs1, r_b_rs2, r_b_rd;
  logic       r_b_wr;

  logic w_conflict, w_sb_stall, w_accept, w_fire_split, w_fire_b_pair;

  // B reads or overwrites the register A is writing; x0 never conflicts.
  assign w_conflict = in_B_valid & in_A_wr & (in_A_rd != 5'd0) &
                      ((in_A_rd == in_B_rs1) | (in_A_rd == in_B_rs2) |
                       (in_B_wr & (in_A_rd == in_B_rd)));

  assign in_ready      = ~reset & (r_state == ST_PAIR) & ~hold & ~w_sb_stall;
  assign w_accept      = in_valid & in_ready;
  assign w_fire_b_pair = w_accept & in_B_valid & ~w_conflict;
  assign w_fire_split  = ~reset & (r_state == ST_SPLIT) & ~hold & ~w_sb_stall;
  assign dbg_state     = r_state;

`ifdef ISSUE_SCOREBOARD_EN
  logic [31:0] r_pend;
  logic [31:0] w_set, w_clr;

  function automatic logic busy(input logic [31:0] p, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic wr);
    return p[rs1] | p[rs2] | (wr & p[rd]);
  endfunction

  // Stall looks only at registered pending bits, so a writeback frees its
  // register one cycle after it is reported.
  always_comb begin
    w_sb_stall = 1'b0;
    if (r_state == ST_PAIR)
      w_sb_stall = busy(r_pend, in_A_rs1, in_A_rs2, in_A_rd, in_A_wr) |
                   (in_B_valid & ~w_conflict &
                    busy(r_pend, in_B_rs1, in_B_rs2, in_B_rd, in_B_wr));
    else
      w_sb_stall = busy(r_pend, r_b_rs1, r_b_rs2, r_b_rd, r_b_wr);
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (wb_A_wr) w_clr[wb_A_rd] = 1'b1;
    if (wb_B_wr) w_clr[wb_B_rd] = 1'b1;
    if (w_accept & in_A_wr)      w_set[in_A_rd] = 1'b1;
    if (w_fire_b_pair & in_B_wr) w_set[in_B_rd] = 1'b1;
    if (w_fire_split & r_b_wr)   w_set[r_b_rd]  = 1'b1;
    w_set[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) r_pend <= '0;
    else       r_pend <= (r_pend & ~w_clr) | w_set;
  end
`else
  logic w_unused_wb;
  assign w_sb_stall  = 1'b0;
  assign w_unused_wb = ^{wb_A_rd, wb_B_rd, wb_A_wr, wb_B_wr};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_PAIR;
      r_b_rs1     <= '0;
      r_b_rs2     <= '0;
      r_b_rd      <= '0;
      r_b_wr      <= 1'b0;
      out_A_valid <= 1'b0;
      out_B_valid <= 1'b0;
      out_A_rs1   <= '0;
      out_A_rs2   <= '0;
      out_A_rd    <= '0;
      out_A_wr    <= 1'b0;
      out_B_rs1   <= '0;
      out_B_rs2   <= '0;
      out_B_rd    <= '0;
      out_B_wr    <= 1'b0;
    end else if (!hold) begin
      out_A_valid <= 1'b0;
      out_B_valid <= 1'b0;
      if (w_accept) begin
        out_A_valid <= 1'b1;
        out_A_rs1   <= in_A_rs1;
        out_A_rs2   <= in_A_rs2;
        out_A_rd    <= in_A_rd;
        out_A_wr    <= in_A_wr;
        if (w_conflict) begin
          r_b_rs1 <= in_B_rs1;
          r_b_rs2 <= in_B_rs2;
          r_b_rd  <= in_B_rd;
          r_b_wr  <= in_B_wr;
          r_state <= ST_SPLIT;
        end else if (in_B_valid) begin
          out_B_valid <= 1'b1;
          out_B_rs1   <= in_B_rs1;
          out_B_rs2   <= in_B_rs2;
          out_B_rd    <= in_B_rd;
          out_B_wr    <= in_B_wr;
        end
      end else if (w_fire_split) begin
        out_B_valid <= 1'b1;
        out_B_rs1   <= r_b_rs1;
        out_B_rs2   <= r_b_rs2;
        out_B_rd    <= r_b_rd;
        out_B_wr    <= r_b_wr;
        r_state     <= ST_PAIR;
      end
    end
  end
endmodule
